// File: rtl/tx_external_shift.sv
// Purpose: serialises a 128-bit message onto an 8-bit bus, MSB byte first, holding each byte BYTE_CYCLES clocks.
// Latency: byte 0 appears on data_send at the start edge; the block returns to idle after 16*BYTE_CYCLES edges.
// Backpressure: none; stop aborts synchronously and msg_tx_ctrl is ignored until the block is back in idle.
module tx_external_shift #(
    parameter int BYTE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         msg_tx_ctrl,
    input  logic [127:0] msg_1,
    input  logic         stop,
    output logic [7:0]   data_send
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(BYTE_CYCLES - 1);
    localparam logic [3:0] IDX_LAST = 4'd15;

    state_t         state_q, state_d;
    logic [127:0]   msg_q, msg_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [7:0]     data_q, data_d;

    logic           byte_done;
    logic [3:0]     idx_inc;
    logic [6:0]     next_base;

    // Byte k sits at bit offset (15-k)*8, which for a 4-bit k is simply {~k, 3'b000}.
    assign byte_done = (cnt_q == CNT_LAST);
    assign idx_inc   = idx_q + 4'd1;
    assign next_base = {~idx_inc, 3'b000};

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop always wins, and the final byte edge returns to idle without restarting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!stop && msg_tx_ctrl) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (stop || (byte_done && (idx_q == IDX_LAST))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: message latch, byte index, hold counter and the outgoing byte.
    always_comb begin
        msg_d  = msg_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (stop) begin
            idx_d  = 4'd0;
            cnt_d  = 8'd0;
            data_d = 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d  = 4'd0;
                    cnt_d  = 8'd0;
                    data_d = 8'h00;
                    if (msg_tx_ctrl) begin
                        msg_d  = msg_1;
                        data_d = msg_1[127:120];
                    end
                end
                ST_SEND: begin
                    if (byte_done) begin
                        cnt_d = 8'd0;
                        if (idx_q == IDX_LAST) begin
                            idx_d  = 4'd0;
                            data_d = 8'h00;
                        end else begin
                            idx_d  = idx_inc;
                            data_d = msg_q[next_base +: 8];
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    idx_d  = 4'd0;
                    cnt_d  = 8'd0;
                    data_d = 8'h00;
                end
            endcase
        end
    end

    // Datapath registers; reset clears everything including the latched message.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            msg_q  <= '0;
            idx_q  <= 4'd0;
            cnt_q  <= 8'd0;
            data_q <= 8'h00;
        end else begin
            msg_q  <= msg_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data_send = data_q;

endmodule

// File: tb/tb_tx_external_shift.sv
// Purpose: directed self-checking bench for tx_external_shift with BYTE_CYCLES=4.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: not applicable.
module tb_tx_external_shift;

    logic         clk;
    logic         nrst;
    logic         msg_tx_ctrl;
    logic [127:0] msg_1;
    logic         stop;
    logic [7:0]   data_send;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] MSG_SMALL = 128'd479762576;
    localparam logic [127:0] MSG_ORDER = 128'h0102030405060708090A0B0C0D0E0F10;

    tx_external_shift #(.BYTE_CYCLES(4)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .msg_tx_ctrl(msg_tx_ctrl),
        .msg_1      (msg_1),
        .stop       (stop),
        .data_send  (data_send)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int n, input logic [7:0] exp);
        checks++;
        assert (data_send === exp)
        else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, data_send, exp);
        end
    endtask

    // Hand-derived waveform for the 0x1C989890 message: twelve zero bytes, then 1C, 98, 98, 90.
    function automatic logic [7:0] exp_small(input int n);
        if (n < 48)      return 8'h00;
        else if (n < 52) return 8'h1C;
        else if (n < 60) return 8'h98;
        else if (n < 64) return 8'h90;
        else             return 8'h00;
    endfunction

    // Ordered message: byte k is k+1, each held four cycles, then idle.
    function automatic logic [7:0] exp_order(input int n);
        if (n < 64) return 8'(n / 4 + 1);
        else        return 8'h00;
    endfunction

    initial begin
        nrst        = 1'b0;
        msg_tx_ctrl = 1'b0;
        msg_1       = '0;
        stop        = 1'b0;

        // Reset, then idle for 20 cycles.
        #3;
        chk("reset_async", 0, 8'h00);
        step();
        chk("reset_held", 0, 8'h00);
        nrst = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            chk("idle", n, 8'h00);
        end

        // Basic send with leading zero bytes.
        msg_1       = MSG_SMALL;
        msg_tx_ctrl = 1'b1;
        step();
        msg_tx_ctrl = 1'b0;
        chk("basic", 0, exp_small(0));
        for (int n = 1; n < 110; n++) begin
            step();
            chk("basic", n, exp_small(n));
        end

        // Byte order; message changed mid-send must not matter.
        msg_1       = MSG_ORDER;
        msg_tx_ctrl = 1'b1;
        step();
        msg_tx_ctrl = 1'b0;
        chk("order", 0, exp_order(0));
        for (int n = 1; n < 70; n++) begin
            step();
            if (n == 5) msg_1 = '1;
            chk("order", n, exp_order(n));
        end

        // Abort at t0+10, retrigger at t0+12.
        msg_1       = MSG_ORDER;
        msg_tx_ctrl = 1'b1;
        step();
        msg_tx_ctrl = 1'b0;
        chk("abort_pre", 0, 8'h01);
        for (int n = 1; n < 10; n++) begin
            step();
            chk("abort_pre", n, exp_order(n));
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("abort_stop", 10, 8'h00);
        step();
        chk("abort_idle", 11, 8'h00);
        msg_tx_ctrl = 1'b1;
        step();
        msg_tx_ctrl = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n > 0) step();
            chk("retrigger", n, exp_order(n));
        end

        // stop beats msg_tx_ctrl in idle.
        stop = 1'b1;
        step();
        chk("stop_in_send", 0, 8'h00);
        msg_tx_ctrl = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("stop_priority", n, 8'h00);
        end
        msg_tx_ctrl = 1'b0;
        stop        = 1'b0;
        step();
        chk("stop_release", 0, 8'h00);

        // Async reset mid-send with start held high, then back-to-back restart.
        msg_1       = MSG_ORDER;
        msg_tx_ctrl = 1'b1;
        step();
        chk("rst_send", 0, 8'h01);
        for (int n = 1; n <= 30; n++) begin
            step();
            chk("rst_send", n, exp_order(n));
        end
        #2;
        nrst = 1'b0;
        #1;
        chk("rst_mid", 30, 8'h00);
        #2;
        nrst = 1'b1;
        for (int n = 0; n < 65; n++) begin
            step();
            chk("after_rst", n, exp_order(n));
        end
        step();
        chk("restart", 65, 8'h01);
        for (int n = 1; n < 4; n++) begin
            step();
            chk("restart", 65 + n, 8'h01);
        end
        step();
        chk("restart", 69, 8'h02);
        msg_tx_ctrl = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_external_shift.md
TX_EXTERNAL_SHIFT -- requirements
Module: tx_external_shift

Interface
REQ-001 Parameter: BYTE_CYCLES, 4, number of clock cycles each byte is held on data_send (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: nrst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 Port: msg_tx_ctrl  input  1  start request; sampled high in IDLE begins a transmission.
REQ-005 Port: msg_1  input  128  message to transmit; captured on the start edge.
REQ-006 Port: stop  input  1  synchronous abort request.
REQ-007 Port: data_send  output  8  currently transmitted byte, registered; 8'h00 when idle.

Function
REQ-008 The block SHALL implement a two-state FSM: IDLE and SEND.
REQ-009 Internal state SHALL consist of a 128-bit message register, a 4-bit byte index (0..15), a cycle counter (0..BYTE_CYCLES-1), the FSM state, and the data_send register.
REQ-010 In IDLE with msg_tx_ctrl=1 and stop=0 at a rising edge t0, the block SHALL latch msg_1, enter SEND, set byte index 0 and cycle counter 0, and drive data_send = msg_1[127:120] from t0.
REQ-011 Byte k (k=0..15) SHALL be msg[127-8k : 120-8k] of the latched message, most significant byte first.
REQ-012 Byte k SHALL be visible on data_send from edge t0+k*BYTE_CYCLES through the cycle before edge t0+(k+1)*BYTE_CYCLES.
REQ-013 In SEND, at each edge the cycle counter SHALL increment; on reaching BYTE_CYCLES-1 it SHALL wrap to 0 and advance the byte index, loading the next byte into data_send.
REQ-014 When byte 15 has been held BYTE_CYCLES cycles (edge t0+16*BYTE_CYCLES), the block SHALL return to IDLE with data_send = 8'h00.
REQ-015 msg_tx_ctrl SHALL be ignored while in SEND; changes to msg_1 after t0 SHALL NOT affect the transmission in progress.
REQ-016 A new start SHALL be accepted on the first edge back in IDLE or later, and never on the edge that completes byte 15.
REQ-017 stop=1 at any edge SHALL force IDLE, data_send = 8'h00, and byte index and cycle counter to 0.
REQ-018 stop has priority over msg_tx_ctrl when both are high in IDLE; no transmission starts.
REQ-019 A msg_tx_ctrl held high for multiple cycles SHALL start only one transmission; after completion, a still-high msg_tx_ctrl SHALL start a new one (level-sensitive in IDLE).
REQ-020 Zero-valued bytes SHALL be transmitted like any other byte (no suppression of leading zeros).

Reset
REQ-021 nrst=0 SHALL immediately, independent of clk, force IDLE, data_send = 8'h00, and clear the message register, byte index and cycle counter.
REQ-022 Reset asserted mid-transmission SHALL abort it; after release the block SHALL stay in IDLE until a new msg_tx_ctrl.
REQ-023 After nrst deassertion the first start SHALL be accepted on the next rising edge with msg_tx_ctrl=1.

Verification
REQ-024 Reset then idle: nrst pulse low, msg_tx_ctrl=0, stop=0 for 20 cycles -> data_send = 8'h00 throughout.
REQ-025 Basic send (BYTE_CYCLES=4): msg_1 = 128'd479762576 (0x1C989890), one-cycle msg_tx_ctrl pulse at edge t0 -> data_send:
  - 8'h00 for t0..t0+47;
  - 8'h1C for t0+48..t0+51;
  - 8'h98 for t0+52..t0+59;
  - 8'h90 for t0+60..t0+63;
  - 8'h00 from t0+64; IDLE thereafter within a 110-cycle window.
REQ-026 Byte order: msg_1 = 128'h0102...0F10 -> bytes 01,02,...,10 each held 4 cycles; msg_1 changed to all-ones at t0+5 -> no effect on the transmission.
REQ-027 Abort: stop=1 for one cycle at t0+10 -> data_send = 8'h00 from t0+10; retrigger at t0+12 -> byte 0 restarts at t0+12.
REQ-028 Async reset mid-send at t0+30 (between edges) -> data_send = 8'h00 immediately; msg_tx_ctrl held high through completion -> second transmission starts on the first IDLE edge after completion.
